// File: rtl/npu_act_norm_engine.sv
// npu_act_norm_engine: activation plus min-max normalisation of an N x N frame with a serial restoring divider
module npu_act_norm_engine #(
    parameter int N          = 10,
    parameter int DW         = 16,
    parameter int OW         = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        out_data,
    output logic                 busy,
    output logic                 done
);
    localparam int NN = N * N;
    localparam int CW = NN > 1 ? $clog2(NN) : 1;
    localparam int BW = OW > 1 ? $clog2(OW) : 1;
    localparam int RW = DW + 1;
    localparam int NW = DW + 1 + OW;
    localparam logic [NW-1:0] FS = NW'((1 << OW) - 1);
    localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, NORM, DONE} state_t;
    typedef enum logic [1:0] {PH_RD, PH_DIV, PH_OUT} phase_t;

    state_t state_q, state_d;
    phase_t ph_q, ph_d;
    logic [1:0] mode_q, mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic signed [DW-1:0] min_q, min_d, max_q, max_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [OW-1:0] nsh_q, nsh_d, quo_q, quo_d;
    logic [BW-1:0] bit_q, bit_d;
    logic signed [DW-1:0] mem_q [NN];
    logic signed [DW-1:0] act, leak, rd;
    logic [RW-1:0] diff, rng;
    logic [NW-1:0] num;
    logic [RW:0] trial;
    logic ge, wr_en;

    // activation of the incoming element and the datapath of the current output element
    always_comb begin
        leak  = in_data >>> LEAK_SHIFT;
        act   = mode_q == 2'd1 ? (in_data[DW-1] ? SMIN ^ SMIN : in_data) :
                mode_q == 2'd2 ? (in_data[DW-1] ? leak : in_data) : in_data;
        rd    = mem_q[cnt_q];
        diff  = {rd[DW-1], rd} - {min_q[DW-1], min_q};
        rng   = {max_q[DW-1], max_q} - {min_q[DW-1], min_q};
        num   = NW'(diff) * FS;
        trial = {rem_q, nsh_q[OW-1]};
        ge    = trial >= {1'b0, rng};
    end

    // next-state logic: frame control, load bookkeeping and one quotient bit per divide cycle
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        min_d   = min_q;
        max_d   = max_q;
        rem_d   = rem_q;
        nsh_d   = nsh_q;
        quo_d   = quo_q;
        bit_d   = bit_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                mode_d  = mode;
                cnt_d   = '0;
                min_d   = SMAX;
                max_d   = SMIN;
                state_d = LOAD;
            end
            LOAD: if (in_valid) begin
                wr_en = 1'b1;
                min_d = act < min_q ? act : min_q;
                max_d = act > max_q ? act : max_q;
                cnt_d = cnt_q == CW'(NN - 1) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CW'(NN - 1)) begin
                    state_d = NORM;
                    ph_d    = PH_RD;
                end
            end
            NORM: case (ph_q)
                PH_RD: begin
                    rem_d = num[NW-1:OW];
                    nsh_d = num[OW-1:0];
                    quo_d = '0;
                    bit_d = '0;
                    ph_d  = rng == '0 ? PH_OUT : PH_DIV;
                end
                PH_DIV: begin
                    rem_d = ge ? RW'(trial - {1'b0, rng}) : trial[RW-1:0];
                    quo_d = {quo_q[OW-2:0], ge};
                    nsh_d = nsh_q << 1;
                    bit_d = bit_q + 1'b1;
                    ph_d  = bit_q == BW'(OW - 1) ? PH_OUT : PH_DIV;
                end
                PH_OUT: if (out_ready) begin
                    ph_d    = PH_RD;
                    cnt_d   = cnt_q == CW'(NN - 1) ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q == CW'(NN - 1) ? DONE : NORM;
                end
                default: ph_d = PH_RD;
            endcase
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous abort of any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= PH_RD;
            mode_q  <= '0;
            cnt_q   <= '0;
            min_q   <= SMAX;
            max_q   <= SMIN;
            rem_q   <= '0;
            nsh_q   <= '0;
            quo_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            rem_q   <= rem_d;
            nsh_q   <= nsh_d;
            quo_q   <= quo_d;
            bit_q   <= bit_d;
        end
    end

    // frame buffer holding activated elements in arrival order
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[cnt_q] <= act;
    end

    assign in_ready  = state_q == LOAD;
    assign out_valid = state_q == NORM && ph_q == PH_OUT;
    assign out_data  = quo_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
endmodule

// File: tb/tb_npu_act_norm_engine.sv
// tb_npu_act_norm_engine: directed tests of activation, normalisation, flow control and reset
module tb_npu_act_norm_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start, in_valid, out_ready, in_ready, out_valid, busy, done;
    logic [1:0] mode;
    logic signed [15:0] in_data;
    logic [7:0] out_data;

    logic b_start, b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_busy, b_done;
    logic [1:0] b_mode;
    logic signed [15:0] b_in_data;
    logic [7:0] b_out_data;

    npu_act_norm_engine #(.N(2), .DW(16), .OW(8), .LEAK_SHIFT(3)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
    );

    npu_act_norm_engine #(.N(10), .DW(16), .OW(8), .LEAK_SHIFT(3)) dut10 (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy), .done(b_done)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] got [4];
    int stamp [4];
    int ngot, ndone, busy_bad;
    bit tmo;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input logic [1:0] m, input logic signed [15:0] a, b, c, d);
        logic signed [15:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        start = 1'b1;
        mode = m;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = v[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int maxcyc);
        bit pdone;
        pdone = 1'b0;
        ngot = 0; ndone = 0; busy_bad = 0; tmo = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < maxcyc; c++) begin
            if (pdone) begin
                if (busy !== 1'b0) busy_bad++;
                tmo = 1'b0;
                break;
            end
            if (out_valid === 1'b1) begin
                if (ngot < 4) begin
                    got[ngot] = out_data;
                    stamp[ngot] = c;
                end
                ngot++;
            end
            if (done === 1'b1) begin
                ndone++;
                if (busy !== 1'b1) busy_bad++;
            end
            pdone = done === 1'b1;
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL rst_out_data got %0d exp 0", out_data); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rst_busy10 got %b exp 0", b_busy); end
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 16'sd77;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_in_valid got ready %b busy %b exp 0 0", in_ready, busy); end
        in_valid = 1'b0;
    endtask

    task automatic test_relu();
        logic [7:0] e [4];
        e[0] = 8'd0; e[1] = 8'd0; e[2] = 8'd127; e[3] = 8'd255;
        load4(2'd1, -16'sd4, 16'sd0, 16'sd10, 16'sd20);
        collect(200);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL relu_timeout got %b exp 0", tmo); end
        checks++; if (ngot != 4) begin errors++; $display("FAIL relu_count got %0d exp 4", ngot); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== e[i]) begin errors++; $display("FAIL relu_out%0d got %0d exp %0d", i, got[i], e[i]); end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL relu_done_pulses got %0d exp 1", ndone); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL relu_busy_fall got %0d bad exp 0", busy_bad); end
        checks++; if (stamp[1] - stamp[0] != 10) begin errors++; $display("FAIL relu_spacing got %0d exp 10", stamp[1] - stamp[0]); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL relu_done_after got %b exp 0", done); end
    endtask

    task automatic test_leaky();
        logic [7:0] e [4];
        e[0] = 8'd0; e[1] = 8'd98; e[2] = 8'd9; e[3] = 8'd255;
        load4(2'd2, -16'sd16, 16'sd8, -16'sd8, 16'sd24);
        collect(200);
        checks++; if (tmo !== 1'b0 || ngot != 4) begin errors++; $display("FAIL leaky_count got %0d tmo %b exp 4 0", ngot, tmo); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== e[i]) begin errors++; $display("FAIL leaky_out%0d got %0d exp %0d", i, got[i], e[i]); end
        end
    endtask

    task automatic test_extremes();
        logic [7:0] e [4];
        e[0] = 8'd0; e[1] = 8'd127; e[2] = 8'd255; e[3] = 8'd0;
        for (int m = 0; m < 4; m += 3) begin
            load4(2'(m), -16'sd32768, 16'sd0, 16'sd32767, -16'sd32768);
            collect(200);
            checks++; if (tmo !== 1'b0 || ngot != 4) begin errors++; $display("FAIL ext_m%0d_count got %0d tmo %b exp 4 0", m, ngot, tmo); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (got[i] !== e[i]) begin errors++; $display("FAIL ext_m%0d_out%0d got %0d exp %0d", m, i, got[i], e[i]); end
            end
        end
    endtask

    task automatic test_constant();
        int cnt, bad, sbad, nd, last;
        cnt = 0; bad = 0; sbad = 0; nd = 0; last = 0;
        b_start = 1'b1;
        b_mode = 2'd0;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            b_in_valid = 1'b1;
            b_in_data = 16'sd5;
            tick();
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            if (b_done === 1'b1) begin
                nd++;
                break;
            end
            if (b_out_valid === 1'b1) begin
                cnt++;
                if (b_out_data !== 8'd0) bad++;
                if (cnt > 1 && c - last != 2) sbad++;
                last = c;
            end
            tick();
        end
        b_out_ready = 1'b0;
        checks++; if (cnt != 100) begin errors++; $display("FAIL const_count got %0d exp 100", cnt); end
        checks++; if (bad != 0) begin errors++; $display("FAIL const_nonzero got %0d exp 0", bad); end
        checks++; if (sbad != 0) begin errors++; $display("FAIL const_spacing got %0d bad exp 0", sbad); end
        checks++; if (nd != 1) begin errors++; $display("FAIL const_done got %0d exp 1", nd); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e [4];
        logic [7:0] held;
        bit found, r;
        e[0] = 8'd0; e[1] = 8'd85; e[2] = 8'd170; e[3] = 8'd255;
        found = 1'b0;
        out_ready = 1'b0;
        load4(2'd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4);
        for (int c = 0; c < 50; c++) begin
            if (out_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got %b exp 1", found); end
        held = out_data;
        checks++; if (held !== 8'd0) begin errors++; $display("FAIL bp_first got %0d exp 0", held); end
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== held) begin errors++; $display("FAIL bp_hold%0d got v %b d %0d exp v 1 d %0d", c, out_valid, out_data, held); end
        end
        ngot = 0; ndone = 0; tmo = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (done === 1'b1) begin
                ndone++;
                tmo = 1'b0;
                break;
            end
            r = 1'($urandom_range(0, 1));
            out_ready = r;
            if (out_valid === 1'b1 && r) begin
                if (ngot < 4) got[ngot] = out_data;
                ngot++;
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (tmo !== 1'b0 || ngot != 4) begin errors++; $display("FAIL bp_transfers got %0d tmo %b exp 4 0", ngot, tmo); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== e[i]) begin errors++; $display("FAIL bp_out%0d got %0d exp %0d", i, got[i], e[i]); end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] e [4];
        e[0] = 8'd0; e[1] = 8'd85; e[2] = 8'd170; e[3] = 8'd255;
        start = 1'b1;
        mode = 2'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 16'sd100; tick();
        in_data = -16'sd100; tick();
        in_data = 16'sd50; tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready got %b exp 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        rst = 1'b0;
        tick();
        load4(2'd0, -16'sd10, 16'sd0, 16'sd10, 16'sd20);
        start = 1'b1;
        mode = 2'd1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL norm_start got busy %b ready %b exp 1 0", busy, in_ready); end
        collect(200);
        checks++; if (tmo !== 1'b0 || ngot != 4 || ndone != 1) begin errors++; $display("FAIL abort_count got %0d done %0d tmo %b exp 4 1 0", ngot, ndone, tmo); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== e[i]) begin errors++; $display("FAIL abort_out%0d got %0d exp %0d", i, got[i], e[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; mode = 2'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        b_start = 1'b0; b_mode = 2'd0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        test_reset();
        test_relu();
        test_leaky();
        test_extremes();
        test_constant();
        test_backpressure();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
